// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser. Clips to H_RES x V_RES and merges pixels that fall in one 8-pixel burst into a masked write.
// Latency: one SETUP cycle after trigger, then one pixel per STEP cycle, plus two cycles for each burst flush.
// Backpressure: af_full/wdf_full stall a flush with its outputs held and the line state frozen; wr_en stays low while blocked.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   LE_ready             idle, accepts a new line
//   LE_color/_valid      colour load strobe
//   LE_point, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid
//                        endpoint load strobes
//   LE_trigger           starts a line
//   LE_frame_base        frame byte base
//   af_full, af_addr_din, af_wr_en
//                        DDR address FIFO
//   wdf_full, wdf_din, wdf_mask_din, wdf_wr_en
//                        DDR write-data FIFO; a mask bit of 1 means the byte is not written
module line_raster_engine #(
   parameter int COORD_W = 10,
   parameter int H_RES   = 1024,
   parameter int V_RES   = 768
) (
   input  logic               clk,
   input  logic               rst,
   output logic               LE_ready,
   input  logic [31:0]        LE_color,
   input  logic [COORD_W-1:0] LE_point,
   input  logic               LE_color_valid,
   input  logic               LE_x0_valid,
   input  logic               LE_y0_valid,
   input  logic               LE_x1_valid,
   input  logic               LE_y1_valid,
   input  logic               LE_trigger,
   input  logic [31:0]        LE_frame_base,
   input  logic               af_full,
   input  logic               wdf_full,
   output logic [30:0]        af_addr_din,
   output logic               af_wr_en,
   output logic [127:0]       wdf_din,
   output logic [15:0]        wdf_mask_din,
   output logic               wdf_wr_en
);

   localparam int EW = COORD_W + 2;       // signed error / delta width
   localparam int KW = 2 * COORD_W - 3;   // burst key width {y, x[hi]}
   localparam logic [COORD_W-1:0] ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP, S_FLUSH0, S_FLUSH1} state_t;
   state_t r_state, w_next;

   // Values from the load strobes. These are used only by the next line.
   logic [31:0]        r_color;
   logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
   // Copy of the line currently being drawn, taken at trigger.
   logic [31:0]        r_lcolor;
   logic [COORD_W-1:0] r_lx0, r_ly0, r_lx1, r_ly1;
   // Bresenham state
   logic [COORD_W-1:0] r_x, r_y;
   logic signed [EW-1:0] r_dx, r_dy, r_err;
   logic               r_sx_neg, r_sy_neg;
   // Pending burst
   logic [KW-1:0]      r_key;
   logic [7:0]         r_mask;
   logic               r_pend;
   logic               r_done;

   logic signed [EW-1:0] w_dx_raw, w_dy_raw, w_adx, w_ady;
   logic signed [EW:0]   w_e2;
   logic               w_step_x, w_step_y;
   logic               w_vis, w_last, w_conflict;
   logic [KW-1:0]      w_key;
   logic [7:0]         w_slot_bit;
   logic [30:0]        w_addr;
   logic [15:0]        w_mask0, w_mask1;
   logic               w_unused_base_msb;

   assign w_unused_base_msb = LE_frame_base[31];

   assign w_dx_raw = $signed({2'b00, r_lx1}) - $signed({2'b00, r_lx0});
   assign w_dy_raw = $signed({2'b00, r_ly1}) - $signed({2'b00, r_ly0});
   assign w_adx    = w_dx_raw[EW-1] ? -w_dx_raw : w_dx_raw;
   assign w_ady    = w_dy_raw[EW-1] ? -w_dy_raw : w_dy_raw;

   // e2 has one extra bit, so 2*err cannot overflow.
   assign w_e2     = {r_err, 1'b0};
   assign w_step_x = (w_e2 >= $signed({r_dy[EW-1], r_dy}));
   assign w_step_y = (w_e2 <= $signed({r_dx[EW-1], r_dx}));

   assign w_vis      = ({{(32-COORD_W){1'b0}}, r_x} < H_RES) &&
                       ({{(32-COORD_W){1'b0}}, r_y} < V_RES);
   assign w_key      = {r_y, r_x[COORD_W-1:3]};
   assign w_slot_bit = 8'b1 << r_x[2:0];
   assign w_last     = (r_x == r_lx1) && (r_y == r_ly1);
   // A visible pixel outside the pending burst has to wait until that burst is flushed.
   assign w_conflict = w_vis && r_pend && (w_key != r_key);

   assign w_addr = LE_frame_base[30:0] | {{(31-KW-2){1'b0}}, r_key, 2'b00};

   // Lane 0 (lowest x) is in the top 32 bits and uses mask bits [15:12].
   always_comb begin
      w_mask0 = 16'hFFFF;
      w_mask1 = 16'hFFFF;
      for (int l = 0; l < 4; l++) begin
         w_mask0[15-4*l -: 4] = {4{~r_mask[l]}};
         w_mask1[15-4*l -: 4] = {4{~r_mask[4+l]}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_color <= '0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
      end else begin
         if (LE_color_valid) r_color <= LE_color;
         if (LE_x0_valid)    r_x0    <= LE_point;
         if (LE_y0_valid)    r_y0    <= LE_point;
         if (LE_x1_valid)    r_x1    <= LE_point;
         if (LE_y1_valid)    r_y1    <= LE_point;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lcolor <= '0;
         r_lx0    <= '0;
         r_ly0    <= '0;
         r_lx1    <= '0;
         r_ly1    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_dx     <= '0;
         r_dy     <= '0;
         r_err    <= '0;
         r_sx_neg <= 1'b0;
         r_sy_neg <= 1'b0;
         r_key    <= '0;
         r_mask   <= '0;
         r_pend   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (LE_trigger) begin
                  r_lcolor <= r_color;
                  r_lx0    <= r_x0;
                  r_ly0    <= r_y0;
                  r_lx1    <= r_x1;
                  // y1 may arrive in the same cycle as the trigger.
                  r_ly1    <= LE_y1_valid ? LE_point : r_y1;
               end
            end
            S_SETUP: begin
               r_x      <= r_lx0;
               r_y      <= r_ly0;
               r_dx     <= w_adx;
               r_dy     <= -w_ady;
               r_sx_neg <= w_dx_raw[EW-1];
               r_sy_neg <= w_dy_raw[EW-1];
               r_err    <= w_adx - w_ady;
               r_mask   <= '0;
               r_pend   <= 1'b0;
               r_done   <= 1'b0;
            end
            S_STEP: begin
               if (!w_conflict) begin
                  if (w_vis) begin
                     r_key  <= w_key;
                     r_mask <= r_mask | w_slot_bit;
                     r_pend <= 1'b1;
                  end
                  if (w_last) begin
                     r_done <= 1'b1;
                  end else begin
                     if (w_step_x) r_x <= r_sx_neg ? r_x - ONE : r_x + ONE;
                     if (w_step_y) r_y <= r_sy_neg ? r_y - ONE : r_y + ONE;
                     r_err <= r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
                  end
               end
            end
            S_FLUSH1: begin
               if (!wdf_full) begin
                  r_mask <= '0;
                  r_pend <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next       = r_state;
      LE_ready     = 1'b0;
      af_wr_en     = 1'b0;
      wdf_wr_en    = 1'b0;
      af_addr_din  = '0;
      wdf_din      = '0;
      wdf_mask_din = 16'hFFFF;
      case (r_state)
         S_IDLE: begin
            LE_ready = 1'b1;
            if (LE_trigger) w_next = S_SETUP;
         end
         S_SETUP: w_next = S_STEP;
         S_STEP: begin
            if (w_conflict)  w_next = S_FLUSH0;
            else if (w_last) w_next = (r_pend || w_vis) ? S_FLUSH0 : S_IDLE;
         end
         S_FLUSH0: begin
            af_addr_din  = w_addr;
            wdf_din      = {4{r_lcolor}};
            wdf_mask_din = w_mask0;
            if (!af_full && !wdf_full) begin
               af_wr_en  = 1'b1;
               wdf_wr_en = 1'b1;
               w_next    = S_FLUSH1;
            end
         end
         S_FLUSH1: begin
            af_addr_din  = w_addr;
            wdf_din      = {4{r_lcolor}};
            wdf_mask_din = w_mask1;
            if (!wdf_full) begin
               wdf_wr_en = 1'b1;
               w_next    = r_done ? S_IDLE : S_STEP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine. It decodes the FIFO writes back into pixels and compares them with a Bresenham reference.
module tb_line_raster_engine;

   localparam int HR = 1024;
   localparam int VR = 768;
   localparam logic [31:0] BASE = 32'h1230_0000;
   localparam logic [31:0] RED  = 32'h00FF_0000;
   localparam logic [31:0] GRN  = 32'h0000_FF00;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         LE_ready;
   logic [31:0]  LE_color = '0;
   logic [9:0]   LE_point = '0;
   logic         LE_color_valid = 1'b0;
   logic         LE_x0_valid = 1'b0;
   logic         LE_y0_valid = 1'b0;
   logic         LE_x1_valid = 1'b0;
   logic         LE_y1_valid = 1'b0;
   logic         LE_trigger = 1'b0;
   logic [31:0]  LE_frame_base = BASE;
   logic         af_full = 1'b0;
   logic         wdf_full = 1'b0;
   logic [30:0]  af_addr_din;
   logic         af_wr_en;
   logic [127:0] wdf_din;
   logic [15:0]  wdf_mask_din;
   logic         wdf_wr_en;

   int n_checks = 0;
   int n_err    = 0;

   logic [30:0]  af_q[$];
   logic [127:0] wd_q[$];
   logic [15:0]  wm_q[$];
   int           full_viol = 0;
   bit           rand_full = 1'b0;

   always #5 clk = ~clk;

   line_raster_engine #(.COORD_W(10), .H_RES(HR), .V_RES(VR)) dut (
      .clk(clk), .rst(rst), .LE_ready(LE_ready),
      .LE_color(LE_color), .LE_point(LE_point),
      .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
      .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger),
      .LE_frame_base(LE_frame_base), .af_full(af_full), .wdf_full(wdf_full),
      .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
      .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
   );

   // FIFO-side capture on the falling edge
   always @(negedge clk) begin
      if (af_wr_en) af_q.push_back(af_addr_din);
      if (wdf_wr_en) begin
         wd_q.push_back(wdf_din);
         wm_q.push_back(wdf_mask_din);
      end
      if ((af_wr_en && af_full) || (wdf_wr_en && wdf_full)) full_viol++;
   end

   always @(posedge clk) begin
      #1;
      if (rand_full) begin
         af_full  = ($urandom_range(0, 1) == 1);
         wdf_full = ($urandom_range(0, 1) == 1);
      end else begin
         af_full  = 1'b0;
         wdf_full = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_line(input int x0, input int y0, input int x1, input int y1,
                             input logic [31:0] col);
      @(posedge clk); #1;
      LE_color = col; LE_color_valid = 1'b1;
      @(posedge clk); #1;
      LE_color_valid = 1'b0; LE_point = 10'(x0); LE_x0_valid = 1'b1;
      @(posedge clk); #1;
      LE_x0_valid = 1'b0; LE_point = 10'(y0); LE_y0_valid = 1'b1;
      @(posedge clk); #1;
      LE_y0_valid = 1'b0; LE_point = 10'(x1); LE_x1_valid = 1'b1;
      // y1 is loaded in the same cycle as the trigger.
      @(posedge clk); #1;
      LE_x1_valid = 1'b0; LE_point = 10'(y1); LE_y1_valid = 1'b1; LE_trigger = 1'b1;
      @(posedge clk); #1;
      LE_y1_valid = 1'b0; LE_trigger = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int budget);
      int n;
      n = 0;
      while (!LE_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, LE_ready, 1'b1);
   endtask

   // Decode the writes captured since (af0, wd0) into pixels and compare them with the clipped reference line.
   task automatic check_pixels(input string tag, input int af0, input int wd0,
                               input int x0, input int y0, input int x1, input int y1,
                               input logic [31:0] col, output int n_got, output int max_y);
      int got[int];
      int exp[int];
      int bad, n_af, x, y, dx, dy, sx, sy, err, e2, py, pxh, px;
      logic [30:0]  a;
      logic [127:0] d;
      logic [15:0]  m;
      logic [3:0]   nib;
      logic [31:0]  lane;
      bad = 0;
      max_y = 0;
      n_af = af_q.size() - af0;
      if (wd_q.size() - wd0 != 2 * n_af) bad++;
      else begin
         for (int i = 0; i < n_af; i++) begin
            a = af_q[af0+i];
            if (a[30:19] != BASE[30:19] || a[1:0] != 2'b00) bad++;
            py  = int'(a[18:9]);
            pxh = int'(a[8:2]);
            for (int w = 0; w < 2; w++) begin
               d = wd_q[wd0 + 2*i + w];
               m = wm_q[wd0 + 2*i + w];
               for (int l = 0; l < 4; l++) begin
                  nib  = m[15-4*l -: 4];
                  lane = d[127-32*l -: 32];
                  if (nib == 4'h0) begin
                     px = pxh * 8 + w * 4 + l;
                     if (got.exists(py * 2048 + px)) got[py*2048+px]++;
                     else got[py*2048+px] = 1;
                     if (lane != col) bad++;
                  end else if (nib != 4'hF) bad++;
               end
            end
         end
      end
      dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      sx = (x0 < x1) ? 1 : -1;
      sy = (y0 < y1) ? 1 : -1;
      err = dx + dy;
      x = x0;
      y = y0;
      for (int n = 0; n < 4096; n++) begin
         if (x < HR && y < VR) exp[y*2048+x] = 1;
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
      foreach (got[k]) begin
         if (got[k] != 1) bad++;
         if (!exp.exists(k)) bad++;
         if (k / 2048 > max_y) max_y = k / 2048;
      end
      foreach (exp[k]) if (!got.exists(k)) bad++;
      n_got = got.num();
      chk({tag, " pixel set"}, 128'(bad), 128'(0));
      chk({tag, " pixel count"}, 128'(n_got), 128'(exp.num()));
   endtask

   task automatic scenario1(input string tag);
      int af0, wd0;
      logic [127:0] d;
      af0 = af_q.size();
      wd0 = wd_q.size();
      drive_line(0, 0, 7, 0, RED);
      wait_ready({tag, " ready"}, 200);
      chk({tag, " af count"}, 128'(af_q.size() - af0), 128'(1));
      chk({tag, " wdf count"}, 128'(wd_q.size() - wd0), 128'(2));
      if (af_q.size() - af0 >= 1 && wd_q.size() - wd0 >= 2) begin
         chk({tag, " addr"}, 128'(af_q[af0]), 128'(BASE[30:0]));
         chk({tag, " mask0"}, 128'(wm_q[wd0]), 128'(16'h0000));
         chk({tag, " mask1"}, 128'(wm_q[wd0+1]), 128'(16'h0000));
         d = wd_q[wd0];
         chk({tag, " data0"}, d, {4{RED}});
         d = wd_q[wd0+1];
         chk({tag, " data1"}, d, {4{RED}});
      end
   endtask

   initial begin
      int af0, wd0, n_got, max_y, v0;
      logic [127:0] d;

      // Reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst LE_ready", LE_ready, 1'b1);
      chk("rst af_wr_en", af_wr_en, 1'b0);
      chk("rst wdf_wr_en", wdf_wr_en, 1'b0);
      chk("rst mask", wdf_mask_din, 16'hFFFF);
      chk("rst addr", af_addr_din, 31'h0);
      chk("rst wdf_din", wdf_din, 128'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: horizontal line covering one full burst
      scenario1("t1");

      // 2: single pixel at (3,5)
      af0 = af_q.size();
      wd0 = wd_q.size();
      drive_line(3, 5, 3, 5, GRN);
      wait_ready("t2 ready", 200);
      chk("t2 af count", 128'(af_q.size() - af0), 128'(1));
      if (af_q.size() - af0 >= 1 && wd_q.size() - wd0 >= 2) begin
         chk("t2 addr", 128'(af_q[af0]), 128'(BASE[30:0] | 31'h0000_0A00));
         chk("t2 mask0", 128'(wm_q[wd0]), 128'(16'hFFF0));
         chk("t2 mask1", 128'(wm_q[wd0+1]), 128'(16'hFFFF));
         d = wd_q[wd0];
         chk("t2 lane3", 128'(d[31:0]), 128'(GRN));
      end

      // 3: full-screen diagonal
      af0 = af_q.size();
      wd0 = wd_q.size();
      drive_line(0, 0, 1023, 767, RED);
      wait_ready("t3 ready", 20000);
      check_pixels("t3", af0, wd0, 0, 0, 1023, 767, RED, n_got, max_y);
      chk("t3 n pixels", 128'(n_got), 128'(1024));
      chk("t3 last y", 128'(max_y), 128'(767));

      // 4: steep line crossing the bottom edge
      af0 = af_q.size();
      wd0 = wd_q.size();
      drive_line(1020, 760, 1023, 775, GRN);
      wait_ready("t4 ready", 2000);
      check_pixels("t4", af0, wd0, 1020, 760, 1023, 775, GRN, n_got, max_y);
      chk("t4 clipped y", 128'(max_y < VR), 128'(1));

      // 5: diagonal with random FIFO backpressure
      v0 = full_viol;
      rand_full = 1'b1;
      af0 = af_q.size();
      wd0 = wd_q.size();
      drive_line(0, 0, 1023, 767, GRN);
      wait_ready("t5 ready", 40000);
      rand_full = 1'b0;
      check_pixels("t5", af0, wd0, 0, 0, 1023, 767, GRN, n_got, max_y);
      chk("t5 write while full", 128'(full_viol - v0), 128'(0));

      // 6: reset in the middle of a line
      drive_line(0, 0, 1023, 767, RED);
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("t6 busy before rst", LE_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6 ready after rst", LE_ready, 1'b1);
      chk("t6 af_wr_en after rst", af_wr_en, 1'b0);
      af0 = af_q.size();
      wd0 = wd_q.size();
      repeat (100) @(negedge clk);
      chk("t6 af writes after rst", 128'(af_q.size() - af0), 128'(0));
      chk("t6 wdf writes after rst", 128'(wd_q.size() - wd0), 128'(0));
      scenario1("t6 t1");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
